// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int REG_ZERO    = 0;
    localparam int STALL_CNT_W = 16;
    localparam int MD_CNT_W    = 4;

endpackage

// File: rtl/md_latency_counter.sv
// Down-counter timing the mul/div busy window; last is high while count==1.
import pipe_ctrl_pkg::*;

module md_latency_counter (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                last
);

    logic [MD_CNT_W-1:0] count;

    // Falling edge, in step with the pipeline registers.
    always_ff @(negedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == MD_CNT_W'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hold/flush sequencing for PC, IF/ID and ID/EX: load-use, taken branch, mul/div busy.
// state   | meaning
// RUN     | normal issue; branch flush or one-cycle load-use bubble
// MD_BUSY | mul/div in flight; Fetch/Decode held, bubbles into Execute
import pipe_ctrl_pkg::*;

module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int REG_W      = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [REG_W-1:0]       rsD,
    input  logic [REG_W-1:0]       rtD,
    input  logic                   useRsD,
    input  logic                   useRtD,
    input  logic                   mdStartD,
    input  logic                   memReadE,
    input  logic                   regWriteE,
    input  logic [REG_W-1:0]       writeRegE,
    input  logic                   branchTakenE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   mdBusy,
    output logic [STALL_CNT_W-1:0] stallCount
);

    state_t state, state_next;
    logic   load_use;
    logic   md_load;
    logic   md_last;

    assign load_use = memReadE & regWriteE & (writeRegE != REG_W'(REG_ZERO)) &
                      ((useRsD & (rsD == writeRegE)) | (useRtD & (rtD == writeRegE)));

    md_latency_counter u_md_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (md_load),
        .load_val (MD_CNT_W'(MD_LATENCY)),
        .dec      (state == MD_BUSY),
        .last     (md_last)
    );

    always_comb begin
        state_next = state;
        stallF     = 1'b0;
        stallD     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        md_load    = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    if (branchTakenE) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (load_use) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end else if (mdStartD) begin
                        state_next = MD_BUSY;
                        md_load    = 1'b1;
                    end
                end
                MD_BUSY: begin
                    stallF = 1'b1;
                    stallD = 1'b1;
                    flushE = 1'b1;
                    if (md_last) begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            state      <= RUN;
            mdBusy     <= 1'b0;
            stallCount <= '0;
        end else begin
            state  <= state_next;
            mdBusy <= (state_next == MD_BUSY);
            if (stallD && (stallCount != '1)) begin
                stallCount <= stallCount + 1'b1;
            end
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the segmented processor. Generates the hold and flush controls for the PC register, the IF/ID registers (instruction and PC+4), and the ID/EX registers. Covers load-use hazards, taken branches resolved in Execute, and a fixed-latency multiply/divide busy window. Keeps a saturating stall-cycle performance counter.

## Interface
- MD_LATENCY, 4: stall cycles following a mul/div issue; legal range 1..15
- REG_W, 5: register-address width
- clk  in  1  clock; state updates on falling edge, same edge as the pipeline registers
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- rsD, rtD  in  REG_W  source registers of the instruction in Decode
- useRsD, useRtD  in  1  Decode instruction actually reads rs / rt
- mdStartD  in  1  Decode instruction is a mul/div
- memReadE  in  1  Execute instruction is a load
- regWriteE  in  1  Execute instruction writes a register
- writeRegE  in  REG_W  destination register of the Execute instruction
- branchTakenE  in  1  branch/jump resolved taken in Execute
- stallF  out  1  hold PC
- stallD  out  1  hold IF/ID registers
- flushD  out  1  clear IF/ID registers to zero on next edge
- flushE  out  1  clear ID/EX registers (bubble) on next edge
- mdBusy  out  1  registered; high while in MD_BUSY
- stallCount  out  16  registered; saturating count of cycles with stallD=1

## Operation
- States: RUN, MD_BUSY. Down-counter mdCnt, 4 bits.
- loadUse = memReadE & regWriteE & (writeRegE != 0) & ((useRsD & rsD==writeRegE) | (useRtD & rtD==writeRegE)).
- Priority in RUN, highest first:
  - branchTakenE: flushD=1, flushE=1, stallF=stallD=0. mdStartD and loadUse ignored; stay RUN.
  - loadUse: stallF=stallD=1, flushE=1, flushD=0. Exactly one bubble, because the load leaves Execute next cycle.
  - mdStartD: outputs all 0 (mul/div advances to Execute). Next state MD_BUSY, mdCnt←MD_LATENCY.
  - otherwise: all outputs 0.
- MD_BUSY: stallF=stallD=1, flushE=1, flushD=0; mdCnt decrements each edge. When mdCnt==1, next state is RUN. branchTakenE, loadUse and mdStartD are ignored.
- Register 0 never causes a hazard.
- stallCount increments on each edge where stallD=1 and reset=0; holds at 0xFFFF.

## Timing
- stallF, stallD, flushD and flushE are combinational (Mealy) from the current state and inputs. They are valid before the falling edge.
- While reset=1: stallF, stallD, flushD and flushE are forced to 0.
- At the reset edge: state←RUN, mdCnt←0, mdBusy←0, stallCount←0. Reset in mid-MD_BUSY aborts the window.
- A mul/div issued at edge N gives mdBusy=1 and stall outputs high for exactly MD_LATENCY cycles after N. The first cycle after that is RUN.
- Load-use stall lasts 1 cycle. If the Execute instruction after the bubble causes a new loadUse, the controller stalls again.
- A mul/div in Decode under loadUse stalls first. It enters MD_BUSY on the cycle it actually issues.
- MD_LATENCY=1: one busy cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum (RUN, MD_BUSY)
  - REG_ZERO constant
  - STALL_CNT_W=16
- Sub-module md_latency_counter (load, decrement, last-flag), instantiated once.
- Hazard compare and output priority stay in the top level.

## Test plan
- Load-use: lw writes r5 in Execute, Decode reads rs=5 with useRsD=1. Required: stallF=stallD=flushE=1 for one cycle, then all 0. stallCount=1.
- Register-zero and unused operand cases produce no stall:
  - lw to r0 with rsD=0
  - writeRegE=7, rtD=7, useRtD=0
- Branch priority: branchTakenE=1 together with loadUse=1 and mdStartD=1. Required: flushD=flushE=1, stalls 0, state stays RUN, mdBusy stays 0.
- Mul/div, MD_LATENCY=4: mdStartD at edge N. Required:
  - mdBusy=1 and stalls high for cycles N+1..N+4
  - RUN at N+5
  - stallCount=4
  - a branchTakenE pulse during the window is ignored
- Reset during MD_BUSY at mdCnt=2. Required: next edge gives RUN, mdBusy=0, stallCount=0, and all outputs 0 while reset is high.
- Saturation: force 65540 stall cycles. Required: stallCount holds at 0xFFFF.
